dot_product_ctrl: RTL and testbench
===================================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, element width in bits (signed two's complement).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, RAM address width.
REQ-003 SHALL have parameter DEPTH, default 8, RAM word count.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*WIDTH+ADDR_WIDTH, accumulator/result width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  request to begin one dot product.
REQ-008 len  in  ADDR_WIDTH+1  element count, sampled with start.
REQ-009 base_a  in  ADDR_WIDTH  first element address of vector A, sampled with start.
REQ-010 base_b  in  ADDR_WIDTH  first element address of vector B, sampled with start.
REQ-011 r_addr_a  out  ADDR_WIDTH  read address to RAM port a.
REQ-012 r_addr_b  out  ADDR_WIDTH  read address to RAM port b.
REQ-013 dout_a  in  WIDTH  RAM port a read data, valid one edge after the address.
REQ-014 dout_b  in  WIDTH  RAM port b read data, valid one edge after the address.
REQ-015 busy  out  1  operation in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 result  out  ACC_WIDTH  signed sum of A[i]*B[i], held until next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-019 In IDLE, start=1 at edge E0 SHALL latch len/base_a/base_b, clear accumulator, drive r_addr_a=base_a, r_addr_b=base_b, go RUN.
REQ-020 In RUN, address registers SHALL advance by 1 per edge, wrapping modulo 2^ADDR_WIDTH; after len addresses issued, go DRAIN.
REQ-021 Pipeline: RAM data at E(i+1), product register (sign-extended 2*WIDTH) at E(i+2), accumulate at E(i+3).
REQ-022 DRAIN SHALL wait until the last product is accumulated (E(len+2)), then go DONE.
REQ-023 done SHALL be high exactly one cycle following edge E(len+3), with result valid at the same edge; DONE returns to IDLE at the next edge.
REQ-024 busy SHALL be high from E0 until done rises, low during the done cycle.
REQ-025 start while busy SHALL be ignored; start during the done cycle SHALL be accepted.
REQ-026 len=0 SHALL produce done one cycle after E1 with result=0 and no accumulation.
REQ-027 len>DEPTH SHALL saturate to DEPTH.
REQ-028 Accumulation SHALL be signed, full precision, no saturation (ACC_WIDTH is sufficient by construction).
REQ-029 Idle r_addr_a/r_addr_b SHALL hold their last value.

Reset
REQ-030 rst SHALL immediately force IDLE, busy=0, done=0, result=0, r_addr_a=0, r_addr_b=0, accumulator and product registers 0.
REQ-031 rst mid-operation SHALL abandon the operation with no done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-032 Package dot_pkg SHALL hold the FSM state type and the ACC_WIDTH default expression.
REQ-033 Multiply register and accumulator SHALL be one sub-module mac_unit (clear, enable, a, b, acc out).

Verification (WIDTH=8, ADDR_WIDTH=3, DEPTH=8)
REQ-034 RAM A[0..3]={1,2,3,4}, B[4..7]={5,6,7,8}, start len=4 base_a=0 base_b=4 -> done at E7, result=70, busy E0..E6.
REQ-035 A[6,7,0]={-128,-128,-128}, B[6,7,0]={-128,-128,-128}, len=3 base_a=base_b=6 -> addresses 6,7,0, result=49152.
REQ-036 len=0 -> done at E1, result=0; len=15 -> treated as 8, done at E11.
REQ-037 start held high across one full operation -> second operation begins at the done cycle, first is not restarted.
REQ-038 rst asserted at E3 of len=8 operation -> all outputs 0 immediately, no done; next start len=2 gives correct result.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the dot-product controller.
package dot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Enough headroom for a full-depth sum of full-scale signed products.
  function automatic int acc_width_default(input int width, input int addr_width);
    return 2 * width + addr_width;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiplier followed by a full-precision accumulator.
module mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [2*WIDTH-1:0] prod_r;
  logic                      prod_v_r;
  logic [ACC_WIDTH-1:0]      acc_r;

  assign prod_s = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));

  // Product stage loads on enable; accumulate stage follows one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r   <= '0;
      prod_v_r <= 1'b0;
      acc_r    <= '0;
    end else if (clear) begin
      prod_r   <= '0;
      prod_v_r <= 1'b0;
      acc_r    <= '0;
    end else begin
      if (enable) begin
        prod_r <= prod_s;
      end else begin
        prod_r <= prod_r;
      end
      prod_v_r <= enable;
      if (prod_v_r) begin
        acc_r <= acc_r + {{(ACC_WIDTH-2*WIDTH){prod_r[2*WIDTH-1]}}, prod_r};
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequences two RAM read ports through a MAC pipeline to form a signed dot product.
module dot_product_ctrl
  import dot_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = acc_width_default(WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic [ADDR_WIDTH-1:0] r_addr_a,
  output logic [ADDR_WIDTH-1:0] r_addr_b,
  input  logic [WIDTH-1:0]      dout_a,
  input  logic [WIDTH-1:0]      dout_b,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CAP = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH:0]   len_sat_s;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic [ADDR_WIDTH-1:0] addr_a_r;
  logic [ADDR_WIDTH-1:0] addr_b_r;
  logic                  addr_v_r;
  logic                  data_v_r;
  logic                  prod_v_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ACC_WIDTH-1:0]  result_r;
  logic [ACC_WIDTH-1:0]  acc_s;
  logic                  accept_s;
  logic                  issue_s;
  logic                  finish_s;
  logic                  pipe_empty_s;

  // Requested length clamped to the RAM depth.
  always_comb begin
    len_sat_s = len;
    if (len > DEPTH_CAP) begin
      len_sat_s = DEPTH_CAP;
    end else begin
      len_sat_s = len;
    end
  end

  assign pipe_empty_s = !addr_v_r && !data_v_r && !prod_v_r;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (len_r == '0) begin
          finish_s     = 1'b1;
          state_next_s = ST_DONE;
        end else if (cnt_r < len_r) begin
          issue_s      = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          finish_s     = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Address issue, valid tracking through the read/multiply stages, and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r    <= '0;
      cnt_r    <= '0;
      addr_a_r <= '0;
      addr_b_r <= '0;
      addr_v_r <= 1'b0;
      data_v_r <= 1'b0;
      prod_v_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      if (accept_s) begin
        len_r    <= len_sat_s;
        addr_a_r <= base_a;
        addr_b_r <= base_b;
        cnt_r    <= {{ADDR_WIDTH{1'b0}}, (len_sat_s != '0)};
        addr_v_r <= (len_sat_s != '0);
      end else if (issue_s) begin
        addr_a_r <= addr_a_r + ADDR_WIDTH'(1);
        addr_b_r <= addr_b_r + ADDR_WIDTH'(1);
        cnt_r    <= cnt_r + (ADDR_WIDTH+1)'(1);
        addr_v_r <= 1'b1;
      end else begin
        addr_v_r <= 1'b0;
      end
      data_v_r <= addr_v_r;
      prod_v_r <= data_v_r;
      busy_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      done_r   <= finish_s;
      if (finish_s) begin
        result_r <= acc_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  mac_unit #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_s),
    .enable (data_v_r),
    .a      (dout_a),
    .b      (dout_b),
    .acc    (acc_s)
  );

  assign r_addr_a = addr_a_r;
  assign r_addr_b = addr_b_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a behavioural dual-port RAM and a result scoreboard.
module tb_dot_product_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [2:0]  base_a;
  logic [2:0]  base_b;
  logic [2:0]  r_addr_a;
  logic [2:0]  r_addr_b;
  logic [7:0]  dout_a;
  logic [7:0]  dout_b;
  logic        busy;
  logic        done;
  logic [18:0] result;

  logic signed [7:0] ram_a [8];
  logic signed [7:0] ram_b [8];
  logic [18:0]       exp_q [$];
  int                total = 0;
  int                bad   = 0;

  dot_product_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .base_a   (base_a),
    .base_b   (base_b),
    .r_addr_a (r_addr_a),
    .r_addr_b (r_addr_b),
    .dout_a   (dout_a),
    .dout_b   (dout_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one edge after the address.
  always @(posedge clk) begin
    dout_a <= ram_a[r_addr_a];
    dout_b <= ram_b[r_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] model(input int l, input int ba, input int bb);
    int n;
    int s;
    n = (l > 8) ? 8 : l;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s += int'(ram_a[(ba + i) % 8]) * int'(ram_b[(bb + i) % 8]);
    end
    return 19'(s);
  endfunction

  // Called #1 after E0; follows the operation until done, checking addresses and busy.
  task automatic track(input string tag, input int l, input int ba, input int bb, input int exp_edge);
    int          n;
    int          done_edge;
    logic        busy_ok;
    logic [18:0] exp_res;
    n         = (l > 8) ? 8 : l;
    done_edge = -1;
    busy_ok   = 1'b1;
    for (int k = 0; k <= 40 && done_edge < 0; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k < n) begin
        check({tag, ":addr_a"}, 32'(r_addr_a), 32'((ba + k) % 8));
        check({tag, ":addr_b"}, 32'(r_addr_b), 32'((bb + k) % 8));
      end
      if (done === 1'b1) begin
        done_edge = k;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    check({tag, ":done_edge"}, 32'(done_edge), 32'(exp_edge));
    check({tag, ":busy_until_done"}, 32'(busy_ok), 32'd1);
    check({tag, ":busy_in_done"}, 32'(busy), 32'd0);
    exp_res = 19'd0;
    if (exp_q.size() > 0) begin
      exp_res = exp_q.pop_front();
    end
    check({tag, ":result"}, 32'(result), 32'(exp_res));
  endtask

  task automatic run_op(input string tag, input int l, input int ba, input int bb, input int exp_edge);
    int n;
    n = (l > 8) ? 8 : l;
    exp_q.push_back(model(l, ba, bb));
    start  = 1'b1;
    len    = 4'(l);
    base_a = 3'(ba);
    base_b = 3'(bb);
    @(posedge clk);
    #1;
    start = 1'b0;
    track(tag, l, ba, bb, exp_edge);
    @(posedge clk);
    #1;
    check({tag, ":done_pulse_end"}, 32'(done), 32'd0);
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check({tag, ":hold_addr_a"}, 32'(r_addr_a), 32'((n > 0) ? (ba + n - 1) % 8 : ba));
    check({tag, ":hold_result"}, 32'(result), 32'(model(l, ba, bb)));
  endtask

  initial begin
    logic seen_done;
    rst    = 1'b1;
    start  = 1'b0;
    len    = 4'd0;
    base_a = 3'd0;
    base_b = 3'd0;
    for (int i = 0; i < 8; i++) begin
      ram_a[i] = 8'sd0;
      ram_b[i] = 8'sd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:result", 32'(result), 32'd0);
    check("reset:addr_a", 32'(r_addr_a), 32'd0);
    check("reset:addr_b", 32'(r_addr_b), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic case: 1*5+2*6+3*7+4*8 = 70.
    ram_a[0] = 8'sd1; ram_a[1] = 8'sd2; ram_a[2] = 8'sd3; ram_a[3] = 8'sd4;
    ram_b[4] = 8'sd5; ram_b[5] = 8'sd6; ram_b[6] = 8'sd7; ram_b[7] = 8'sd8;
    check("model:basic", 32'(model(4, 0, 4)), 32'd70);
    run_op("basic", 4, 0, 4, 7);

    // Most negative operands with address wrap: 3*16384 = 49152.
    ram_a[6] = -8'sd128; ram_a[7] = -8'sd128; ram_a[0] = -8'sd128;
    ram_b[6] = -8'sd128; ram_b[7] = -8'sd128; ram_b[0] = -8'sd128;
    check("model:wrap", 32'(model(3, 6, 6)), 32'd49152);
    run_op("wrap", 3, 6, 6, 6);

    run_op("len0", 0, 2, 3, 1);

    for (int i = 0; i < 8; i++) begin
      ram_a[i] = 8'($urandom_range(0, 255));
      ram_b[i] = 8'($urandom_range(0, 255));
    end
    run_op("rand5", 5, 5, 2, 8);
    run_op("len15", 15, 3, 1, 11);
    run_op("len1", 1, 7, 0, 4);

    // Start held high: second operation starts in the done cycle with new operands.
    exp_q.push_back(model(4, 0, 4));
    start  = 1'b1;
    len    = 4'd4;
    base_a = 3'd0;
    base_b = 3'd4;
    @(posedge clk);
    #1;
    track("held1", 4, 0, 4, 7);
    exp_q.push_back(model(2, 1, 5));
    len    = 4'd2;
    base_a = 3'd1;
    base_b = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held2:busy_restart", 32'(busy), 32'd1);
    track("held2", 2, 1, 5, 5);
    @(posedge clk);
    #1;

    // Reset in the middle of a full-depth operation.
    start  = 1'b1;
    len    = 4'd8;
    base_a = 3'd0;
    base_b = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort:busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:result", 32'(result), 32'd0);
    check("abort:addr_a", 32'(r_addr_a), 32'd0);
    check("abort:addr_b", 32'(r_addr_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end
    end
    check("abort:no_done", 32'(seen_done), 32'd0);
    run_op("after_rst", 2, 3, 5, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
